// File: rtl/conv_pkg.sv
// Shared types, derived widths and arithmetic helpers for the streaming KxK convolution engine.
package conv_pkg;

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    localparam int DEF_IMAGE_COLS = 32;
    localparam int DEF_IMAGE_ROWS = 32;
    localparam int DEF_K          = 5;
    localparam int DEF_IN_WIDTH   = 6;
    localparam int DEF_W_WIDTH    = 6;
    localparam int DEF_OUT_WIDTH  = 18;
    localparam int NUM_TAPS       = DEF_K * DEF_K;
    localparam int ACC_WIDTH      = DEF_IN_WIDTH + DEF_W_WIDTH + clog2(NUM_TAPS);
    localparam int OUT_PER_FRAME  = (DEF_IMAGE_ROWS - DEF_K + 1) * (DEF_IMAGE_COLS - DEF_K + 1);

    // Clamp a sign-extended accumulator into the signed range of an out_width-bit result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] acc, input int out_width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 chained row delay lines; presents the K-pixel column (oldest row first) for the window.
module conv_line_buffer #(
    parameter int IMAGE_COLS = 32,
    parameter int K          = 5,
    parameter int IN_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  shift,
    input  logic [IN_WIDTH-1:0]   pix,
    output logic [K*IN_WIDTH-1:0] column
);

    logic [IN_WIDTH-1:0] rows [K-1][IMAGE_COLS];

    always_ff @(posedge clk) begin
        if (shift) begin
            rows[0][0] <= pix;
            for (int r = 1; r < K - 1; r++) rows[r][0] <= rows[r-1][IMAGE_COLS-1];
            for (int r = 0; r < K - 1; r++)
                for (int c = 1; c < IMAGE_COLS; c++) rows[r][c] <= rows[r][c-1];
        end
    end

    // Slot K-1 is the live pixel; slot K-2-r is the tail of delay line r (r+1 rows back).
    always_comb begin
        column = '0;
        column[(K-1)*IN_WIDTH +: IN_WIDTH] = pix;
        for (int r = 0; r < K - 1; r++) column[(K-2-r)*IN_WIDTH +: IN_WIDTH] = rows[r][IMAGE_COLS-1];
    end

endmodule

// File: rtl/conv_kxk_stream.sv
// Streaming KxK convolution: loadable signed kernel, line-buffered window, 3-stage MAC with saturation.
//   state | meaning
//   LOAD  | collecting K*K kernel weights, pixel input closed
//   RUN   | accepting raster pixels and producing window results
module conv_kxk_stream
    import conv_pkg::*;
#(
    parameter int IMAGE_COLS = DEF_IMAGE_COLS,
    parameter int IMAGE_ROWS = DEF_IMAGE_ROWS,
    parameter int K          = DEF_K,
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int W_WIDTH    = DEF_W_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_valid,
    input  logic [W_WIDTH-1:0]   w_data,
    input  logic                 reload_req,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy_load
);

    localparam int TAPS   = K * K;
    localparam int PROD_W = IN_WIDTH + W_WIDTH;
    localparam int ACC_W  = PROD_W + clog2(TAPS);
    localparam int IDX_W  = clog2(TAPS);
    localparam int COL_W  = clog2(IMAGE_COLS);
    localparam int ROW_W  = clog2(IMAGE_ROWS);

    state_t                    state, state_nx;
    logic [IDX_W-1:0]          w_idx;
    logic [COL_W-1:0]          col;
    logic [ROW_W-1:0]          row;
    logic                      pending;
    logic signed [W_WIDTH-1:0] weight [TAPS];
    logic signed [IN_WIDTH-1:0] window [K][K];
    logic signed [PROD_W-1:0]  prod [TAPS];
    logic signed [ACC_W-1:0]   acc;
    logic [K*IN_WIDTH-1:0]     column;
    logic                      accept, frame_end, at_origin, covered, last_tap;
    logic                      v1, l1, v2, l2;

    assign accept    = (state == RUN) && in_valid;
    assign frame_end = (row == ROW_W'(IMAGE_ROWS - 1)) && (col == COL_W'(IMAGE_COLS - 1));
    assign at_origin = (row == '0) && (col == '0);
    assign covered   = (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
    assign last_tap  = (w_idx == IDX_W'(TAPS - 1));

    conv_line_buffer #(
        .IMAGE_COLS (IMAGE_COLS),
        .K          (K),
        .IN_WIDTH   (IN_WIDTH)
    ) u_line_buffer (
        .clk    (clk),
        .shift  (accept),
        .pix    (in_data),
        .column (column)
    );

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        busy_load = 1'b0;
        case (state)
            LOAD: begin
                busy_load = 1'b1;
                if (w_valid && last_tap) state_nx = RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                // A pixel accepted at the origin opens a new frame, so that reload must wait for its end.
                if (reload_req && at_origin && !in_valid) state_nx = LOAD;
                else if (accept && frame_end && (pending || reload_req)) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            w_idx   <= '0;
            row     <= '0;
            col     <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == LOAD) begin
                pending <= 1'b0;
                if (w_valid) w_idx <= last_tap ? '0 : w_idx + 1'b1;
            end else begin
                if (reload_req) pending <= 1'b1;
                if (accept) begin
                    if (col == COL_W'(IMAGE_COLS - 1)) begin
                        col <= '0;
                        row <= (row == ROW_W'(IMAGE_ROWS - 1)) ? '0 : row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == LOAD) && w_valid) weight[w_idx] <= w_data;
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) window[i][j] <= window[i][j+1];
                window[i][K-1] <= column[i*IN_WIDTH +: IN_WIDTH];
            end
        end
        for (int t = 0; t < TAPS; t++)
            prod[t] <= PROD_W'(window[t / K][t % K]) * PROD_W'(weight[t]);
    end

    always_comb begin
        acc = '0;
        for (int t = 0; t < TAPS; t++) acc = acc + ACC_W'(prod[t]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1        <= 1'b0;
            l1        <= 1'b0;
            v2        <= 1'b0;
            l2        <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            v1        <= accept && covered;
            l1        <= accept && frame_end;
            v2        <= v1;
            l2        <= l1;
            out_valid <= v2;
            out_last  <= l2;
            if (v2) out_data <= OUT_WIDTH'(saturate(64'(acc), OUT_WIDTH));
        end
    end

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Bench for conv_kxk_stream: three configurations checked against a direct convolution model.
`timescale 1ns/1ps
module tb_conv_kxk_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, w_valid, reload_req, in_valid;
    logic [5:0] w_data, in_data;
    int         sel;

    logic        a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [17:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [7:0]  b_out_data;
    logic        c_in_ready, c_out_valid, c_out_last, c_busy;
    logic [17:0] c_out_data;

    conv_kxk_stream dut_a (
        .clk(clk), .rst(rst_n), .w_valid(w_valid && sel == 0), .w_data(w_data),
        .reload_req(reload_req && sel == 0), .in_valid(in_valid && sel == 0), .in_data(in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_last(a_out_last), .busy_load(a_busy));

    conv_kxk_stream #(.OUT_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst_n), .w_valid(w_valid && sel == 1), .w_data(w_data),
        .reload_req(reload_req && sel == 1), .in_valid(in_valid && sel == 1), .in_data(in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_last(b_out_last), .busy_load(b_busy));

    conv_kxk_stream #(.IMAGE_COLS(8), .IMAGE_ROWS(8), .K(3)) dut_c (
        .clk(clk), .rst(rst_n), .w_valid(w_valid && sel == 2), .w_data(w_data),
        .reload_req(reload_req && sel == 2), .in_valid(in_valid && sel == 2), .in_data(in_data),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
        .out_last(c_out_last), .busy_load(c_busy));

    logic cur_ready, cur_busy;
    assign cur_ready = (sel == 0) ? a_in_ready : (sel == 1) ? b_in_ready : c_in_ready;
    assign cur_busy  = (sel == 0) ? a_busy : (sel == 1) ? b_busy : c_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cur_k, cur_cols, cur_rows, cur_ow;
    int wts [49];
    int pix [1024];
    int acc_cyc [1024];
    int exp_q [$];
    int got_d [$];
    int got_c [$];
    bit got_l [$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (a_out_valid) begin got_d.push_back(int'($signed(a_out_data))); got_l.push_back(a_out_last); got_c.push_back(cyc); end
        if (b_out_valid) begin got_d.push_back(int'($signed(b_out_data))); got_l.push_back(b_out_last); got_c.push_back(cyc); end
        if (c_out_valid) begin got_d.push_back(int'($signed(c_out_data))); got_l.push_back(c_out_last); got_c.push_back(cyc); end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic select_dut(input int s);
        sel      = s;
        cur_k    = (s == 2) ? 3 : 5;
        cur_cols = (s == 2) ? 8 : 32;
        cur_rows = cur_cols;
        cur_ow   = (s == 1) ? 8 : 18;
    endtask

    // Direct evaluation of the window sum for every fully covered position, in raster order.
    task automatic build_expected();
        int s, lim;
        exp_q.delete();
        lim = 1 << (cur_ow - 1);
        for (int r = cur_k - 1; r < cur_rows; r++)
            for (int c = cur_k - 1; c < cur_cols; c++) begin
                s = 0;
                for (int i = 0; i < cur_k; i++)
                    for (int j = 0; j < cur_k; j++)
                        s += wts[i*cur_k + j] * pix[(r - cur_k + 1 + i)*cur_cols + (c - cur_k + 1 + j)];
                if (s > lim - 1) s = lim - 1;
                if (s < -lim) s = -lim;
                exp_q.push_back(s);
            end
    endtask

    task automatic clear_results();
        got_d.delete(); got_l.delete(); got_c.delete();
    endtask

    task automatic load_kernel(input int gap_max);
        for (int t = 0; t < cur_k*cur_k; t++) begin
            if (gap_max > 0) begin
                w_valid = 1'b0;
                repeat (int'($urandom_range(0, gap_max))) begin @(posedge clk); #1; end
            end
            w_valid = 1'b1;
            w_data  = 6'(wts[t]);
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
    endtask

    task automatic stream_frame(input int gap_max, input int rel_at, input int rst_at);
        int n, g, w;
        n = cur_rows * cur_cols;
        for (int idx = 0; idx < n; idx++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (g > 0) begin
                in_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            if (idx == rst_at) begin
                checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL rst_pipe_busy out_valid=%0b want=1", a_out_valid); end
                rst_n = 1'b0; #1;
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b want=0", a_out_valid); end
                checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_load got=%0b want=1", a_busy); end
                checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0b want=0", a_in_ready); end
                in_valid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            in_valid   = 1'b1;
            in_data    = 6'(pix[idx]);
            reload_req = (idx == rel_at);
            w = 0;
            while (!cur_ready && w < 50) begin @(posedge clk); #1; w++; end
            if (!cur_ready) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout pixel=%0d in_ready=%0b want=1", idx, cur_ready);
                in_valid = 1'b0; reload_req = 1'b0;
                return;
            end
            acc_cyc[idx] = cyc;
            @(posedge clk); #1;
            reload_req = 1'b0;
        end
        in_valid = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b want=0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b want=0", a_out_valid); end
        checks++; if (a_out_data !== 18'd0) begin errors++; $display("FAIL reset_out_data got=%0h want=0", a_out_data); end
        checks++; if (a_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%0b want=0", a_out_last); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_load got=%0b want=1", a_busy); end
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_stays_load busy=%0b ready=%0b want=1/0", a_busy, a_in_ready); end
        checks++; if (got_d.size() != 0) begin errors++; $display("FAIL reset_no_output got=%0d want=0", got_d.size()); end
    endtask

    task automatic test_defaults();
        select_dut(0);
        for (int t = 0; t < 25; t++) wts[t] = 1;
        for (int p = 0; p < 1024; p++) pix[p] = 1;
        load_kernel(0);
        checks++; if (a_busy !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL dflt_run_entry busy=%0b ready=%0b want=0/1", a_busy, a_in_ready); end
        clear_results();
        build_expected();
        stream_frame(0, -1, -1);
        checks++; if (got_d.size() != 784) begin errors++; $display("FAIL dflt_count got=%0d want=784", got_d.size()); end
        foreach (exp_q[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== 25 || got_l[i] !== (i == 783))
                begin errors++; $display("FAIL dflt_result[%0d] got=%0d/%0b want=25/%0b", i, got_d[i], got_l[i], i == 783); end
        end
        if (got_c.size() > 0) begin
            checks++; if (got_c[0] - acc_cyc[4*32+4] != 3) begin errors++; $display("FAIL dflt_latency got=%0d want=3", got_c[0] - acc_cyc[4*32+4]); end
        end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL dflt_stays_run busy=%0b want=0", a_busy); end
    endtask

    task automatic test_identity();
        select_dut(0);
        // Frame boundary reload from RUN with no pixel pending.
        reload_req = 1'b1;
        @(posedge clk); #1;
        reload_req = 1'b0;
        checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL boundary_reload busy=%0b ready=%0b want=1/0", a_busy, a_in_ready); end
        for (int t = 0; t < 25; t++) wts[t] = (t == 12) ? 1 : 0;
        for (int r = 0; r < 32; r++) for (int c = 0; c < 32; c++) pix[r*32 + c] = (r + c) % 32 - 16;
        load_kernel(2);
        clear_results();
        build_expected();
        stream_frame(3, -1, -1);
        checks++; if (got_d.size() != exp_q.size()) begin errors++; $display("FAIL ident_count got=%0d want=%0d", got_d.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1))
                begin errors++; $display("FAIL ident_result[%0d] got=%0d/%0b want=%0d", i, got_d[i], got_l[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        select_dut(0);
        reload_req = 1'b1;
        @(posedge clk); #1;
        reload_req = 1'b0;
        for (int t = 0; t < 25; t++) wts[t] = int'($urandom_range(0, 63)) - 32;
        for (int p = 0; p < 1024; p++) pix[p] = int'($urandom_range(0, 63)) - 32;
        load_kernel(1);
        clear_results();
        build_expected();
        stream_frame(2, -1, -1);
        checks++; if (got_d.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d want=%0d", got_d.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1))
                begin errors++; $display("FAIL rand_result[%0d] got=%0d/%0b want=%0d", i, got_d[i], got_l[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reload();
        select_dut(0);
        reload_req = 1'b1;
        @(posedge clk); #1;
        reload_req = 1'b0;
        for (int t = 0; t < 25; t++) wts[t] = 1;
        for (int p = 0; p < 1024; p++) pix[p] = 1;
        load_kernel(0);
        clear_results();
        stream_frame(0, 10*32 + 3, -1);
        checks++; if (got_d.size() != 784) begin errors++; $display("FAIL midrl_count got=%0d want=784", got_d.size()); end
        foreach (got_d[i]) begin
            checks++; if (got_d[i] !== 25) begin errors++; $display("FAIL midrl_result[%0d] got=%0d want=25", i, got_d[i]); end
        end
        checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin errors++; $display("FAIL midrl_load busy=%0b ready=%0b want=1/0", a_busy, a_in_ready); end
        for (int t = 0; t < 25; t++) wts[t] = 2;
        load_kernel(0);
        clear_results();
        build_expected();
        stream_frame(0, -1, -1);
        checks++; if (got_d.size() != 784) begin errors++; $display("FAIL midrl2_count got=%0d want=784", got_d.size()); end
        foreach (exp_q[i]) if (i < got_d.size()) begin
            checks++; if (got_d[i] !== exp_q[i] || got_d[i] !== 50) begin errors++; $display("FAIL midrl2_result[%0d] got=%0d want=50", i, got_d[i]); end
        end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL midrl2_run busy=%0b want=0", a_busy); end
    endtask

    task automatic test_reset_mid_frame();
        select_dut(0);
        stream_frame(0, -1, 20*32 + 20);
        for (int t = 0; t < 25; t++) wts[t] = 1;
        load_kernel(0);
        clear_results();
        build_expected();
        stream_frame(0, -1, -1);
        checks++; if (got_d.size() != 784) begin errors++; $display("FAIL rstmid_count got=%0d want=784", got_d.size()); end
        foreach (exp_q[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 783))
                begin errors++; $display("FAIL rstmid_result[%0d] got=%0d/%0b want=%0d", i, got_d[i], got_l[i], exp_q[i]); end
        end
    endtask

    task automatic test_saturation();
        select_dut(1);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                reload_req = 1'b1;
                @(posedge clk); #1;
                reload_req = 1'b0;
                checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL sat_reload busy=%0b want=1", b_busy); end
            end
            for (int t = 0; t < 25; t++) wts[t] = (pass == 0) ? -32 : 31;
            for (int p = 0; p < 1024; p++) pix[p] = -32;
            load_kernel(0);
            clear_results();
            build_expected();
            stream_frame(1, -1, -1);
            checks++; if (got_d.size() != 784) begin errors++; $display("FAIL sat%0d_count got=%0d want=784", pass, got_d.size()); end
            foreach (exp_q[i]) if (i < got_d.size()) begin
                checks++;
                if (got_d[i] !== exp_q[i] || got_d[i] !== ((pass == 0) ? 127 : -128))
                    begin errors++; $display("FAIL sat%0d_result[%0d] got=%0d want=%0d", pass, i, got_d[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_k3();
        select_dut(2);
        for (int t = 0; t < 9; t++) wts[t] = 1;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) pix[r*8 + c] = (r*8 + c) % 64 - 32;
        load_kernel(0);
        clear_results();
        build_expected();
        stream_frame(2, -1, -1);
        checks++; if (got_d.size() != 36) begin errors++; $display("FAIL k3_count got=%0d want=36", got_d.size()); end
        foreach (exp_q[i]) if (i < got_d.size()) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 35))
                begin errors++; $display("FAIL k3_result[%0d] got=%0d/%0b want=%0d/%0b", i, got_d[i], got_l[i], exp_q[i], i == 35); end
        end
    endtask

    initial begin
        rst_n = 1'b0; w_valid = 1'b0; w_data = '0; reload_req = 1'b0; in_valid = 1'b0; in_data = '0;
        select_dut(0);
        repeat (3) begin @(posedge clk); #1; end
        test_reset();
        test_defaults();
        test_identity();
        test_random();
        test_mid_reload();
        test_reset_mid_frame();
        test_saturation();
        test_k3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
